bus_dma_copy: RTL and testbench

// Bus initiator (DMA copy engine) for the SoC bus. It copies a block of 32-bit words from src_addr to dst_addr
// by issuing read/write requests and waiting for rd_ack/wr_ack, the same way picorv32 drives the bus.
// It sits beside the CPU; the top level arbitrates between the two (arbitration is outside this block).

---
 rtl/bus_dma_copy.sv | 100 ++++++++++
 tb/tb_bus_dma_copy.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_copy.sv
// bus_dma_copy: bus-initiator DMA engine copying a block of 32-bit words from src_addr to dst_addr.
// Ports:
//   clk, reset_l                 clock, asynchronous active-low reset
//   start, abort                 1-cycle control pulses (start ignored while busy)
//   src_addr, dst_addr           word-aligned byte addresses, sampled on start
//   word_count                   words to copy, sampled on start
//   busy, done, error            status: busy level, completion pulse, sticky timeout flag
//   bus_addr, bus_wr_data        request address and write data
//   bus_we, bus_re               write byte enables (4'hF or 0) and read request
//   bus_rd_data, bus_rd_ack      read data qualified by read acknowledge
//   bus_wr_ack                   write acknowledge
module bus_dma_copy #(
    parameter int COUNT_WIDTH = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wr_data,
    output logic [3:0]             bus_we,
    output logic                   bus_re,
    input  logic [31:0]            bus_rd_data,
    input  logic                   bus_rd_ack,
    input  logic                   bus_wr_ack
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t state, next;
    logic [31:0] src, dst, src_d, dst_d, addr_d, wdata_d;
    logic [COUNT_WIDTH-1:0] rem, rem_d;
    logic [TW-1:0] wait_cnt, wait_d;
    logic tmo, tmo_fire, load, step, err_d;
    // wait_cnt is zero in the first cycle of every request, so TLAST marks its TIMEOUT-th cycle
    assign tmo = (TIMEOUT != 0) && (wait_cnt == TLAST);
    assign load = state == IDLE && start;
    assign step = state == WR && bus_wr_ack && !abort;
    // an ack in the last allowed cycle still wins over the timeout
    assign tmo_fire = tmo && !abort && ((state == RD && !bus_rd_ack) || (state == WR && !bus_wr_ack));
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            state <= IDLE;
        else
            state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? (word_count == '0 ? FIN : RD) : IDLE;
            RD:      next = abort ? IDLE : bus_rd_ack ? WR : tmo ? FIN : RD;
            WR:      next = abort ? IDLE : bus_wr_ack ? (rem == COUNT_WIDTH'(1) ? FIN : RD) : tmo ? FIN : WR;
            default: next = IDLE;
        endcase
    end
    // next-cycle values of every registered output and datapath register
    always_comb begin
        src_d   = load ? src_addr : step ? src + 32'd4 : src;
        dst_d   = load ? dst_addr : step ? dst + 32'd4 : dst;
        rem_d   = load ? word_count : step ? rem - 1'b1 : rem;
        wait_d  = next != state ? '0 : wait_cnt + 1'b1;
        addr_d  = next == RD ? src_d : next == WR ? dst : bus_addr;
        wdata_d = state == RD && next == WR ? bus_rd_data : bus_wr_data;
        err_d   = load ? 1'b0 : error | tmo_fire;
    end
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            src         <= '0;
            dst         <= '0;
            rem         <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            bus_re      <= 1'b0;
            bus_we      <= 4'h0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            src         <= src_d;
            dst         <= dst_d;
            rem         <= rem_d;
            wait_cnt    <= wait_d;
            busy        <= next != IDLE;
            done        <= state == FIN && !abort;
            error       <= err_d;
            bus_re      <= next == RD;
            bus_we      <= {4{next == WR}};
            bus_addr    <= addr_d;
            bus_wr_data <= wdata_d;
        end
    end
endmodule

// File: tb/tb_bus_dma_copy.sv
// tb_bus_dma_copy: directed bench with a transaction-level copy model checked every cycle.
module tb_bus_dma_copy;
    logic clk = 0, reset_l = 0, start = 0, abort = 0;
    logic [31:0] src_addr = 0, dst_addr = 0;
    logic [15:0] word_count = 0;
    logic busy, done, error, bus_re;
    logic [31:0] bus_addr, bus_wr_data;
    logic [3:0] bus_we;
    logic [31:0] bus_rd_data = 0;
    logic bus_rd_ack = 0, bus_wr_ack = 0;

    typedef struct {bit rd; logic [31:0] addr; logic [31:0] data;} acc_t;
    acc_t q[$];
    logic [31:0] rd_log[$], wr_log[$];
    bit m_busy = 0, active = 0, m_err = 0;
    int m_wait = 0, done_due = -1, cyc = 0;
    int checks = 0, errors = 0;
    int done_cnt = 0, done_cyc = -1, req_cycles = 0, run = 0, last_run = 0;
    int fixed_lat = 1, cur_lat = 1, age = 0;
    bit rand_lat = 0;

    bus_dma_copy #(.COUNT_WIDTH(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset_l(reset_l), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rd_data(bus_rd_data), .bus_rd_ack(bus_rd_ack), .bus_wr_ack(bus_wr_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // memory responder: acks each request after cur_lat waiting cycles
    always @(posedge clk) begin
        #2;
        bus_rd_ack = 0;
        bus_wr_ack = 0;
        bus_rd_data = 32'hDEAD_BEEF;
        if (bus_re || bus_we != 0) begin
            if (age == cur_lat) begin
                if (bus_re) begin
                    bus_rd_ack = 1;
                    bus_rd_data = src_word(bus_addr);
                end else
                    bus_wr_ack = 1;
                age = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 7)) : fixed_lat;
            end else
                age++;
        end else begin
            age = 0;
            cur_lat = rand_lat ? int'($urandom_range(0, 7)) : fixed_lat;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare DUT against the model for the current cycle, then advance the model
    task automatic sample();
        acc_t h;
        bit hv, acked;
        if (!reset_l) begin
            chk("reset_ctl", {busy, done, error, bus_re, bus_we}, 0);
            chk("reset_bus", {bus_addr, bus_wr_data}, 0);
            m_busy = 0; active = 0; m_err = 0; m_wait = 0; done_due = -1; run = 0;
            q.delete();
        end else begin
            hv = active && q.size() > 0;
            if (hv) h = q[0];
            else h = '{1'b0, 32'h0, 32'h0};
            chk("busy", busy, m_busy && cyc != done_due);
            chk("done", done, cyc == done_due);
            chk("error", error, m_err);
            chk("bus_re", bus_re, hv && h.rd);
            chk("bus_we", bus_we, (hv && !h.rd) ? 4'hF : 4'h0);
            if (hv) chk("bus_addr", bus_addr, h.addr);
            if (hv && !h.rd) chk("bus_wr_data", bus_wr_data, h.data);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (bus_re || bus_we != 0) req_cycles++;
            if (bus_re) run++;
            else if (run > 0) begin last_run = run; run = 0; end
            if (cyc == done_due) begin m_busy = 0; done_due = -1; end
            if (abort && m_busy) begin
                m_busy = 0; active = 0; done_due = -1;
                q.delete();
            end else if (start && !m_busy) begin
                m_busy = 1; m_err = 0; m_wait = 0;
                q.delete(); rd_log.delete(); wr_log.delete(); req_cycles = 0;
                for (int i = 0; i < int'(word_count); i++) begin
                    q.push_back(acc_t'{1'b1, src_addr + 32'(4 * i), 32'h0});
                    q.push_back(acc_t'{1'b0, dst_addr + 32'(4 * i), src_word(src_addr + 32'(4 * i))});
                end
                active = word_count != 0;
                if (word_count == 0) done_due = cyc + 2;
            end else if (hv) begin
                acked = h.rd ? bus_rd_ack : bus_wr_ack;
                if (acked) begin
                    if (h.rd) rd_log.push_back(bus_addr);
                    else wr_log.push_back(bus_wr_data);
                    void'(q.pop_front());
                    m_wait = 0;
                    if (q.size() == 0) begin active = 0; done_due = cyc + 2; end
                end else begin
                    m_wait++;
                    if (m_wait == 16) begin
                        active = 0; m_err = 1; done_due = cyc + 2;
                        q.delete();
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, output int sc);
        src_addr = s; dst_addr = d; word_count = n; start = 1; sc = cyc;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int max);
        int n0, k;
        n0 = done_cnt; k = 0;
        while (done_cnt == n0 && k < max) begin tick(); k++; end
        if (done_cnt == n0) begin
            checks++; errors++;
            $display("FAIL wait_done: no done pulse within %0d cycles", max);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sc, dc, k;
        @(posedge clk); #1;
        repeat (3) tick();
        reset_l = 1;
        repeat (2) tick();
        // 4 words, 1-cycle responder: 4 cycles per word plus FIN
        go(32'h0001_0000, 32'h0000_0100, 4, sc);
        wait_done(60);
        chk("t1_done_lat", done_cyc - sc, 18);
        chk("t1_reads", rd_log.size(), 4);
        chk("t1_writes", wr_log.size(), 4);
        chk("t1_data0", wr_log[0], 32'h5A5B_0000);
        chk("t1_data3", wr_log[3], 32'h5A5B_000C);
        chk("t1_error", error, 0);
        // empty copy
        go(32'h10, 32'h20, 0, sc);
        wait_done(10);
        chk("t2_done_lat", done_cyc - sc, 2);
        chk("t2_no_req", req_cycles, 0);
        // read never acked
        fixed_lat = 1000;
        tick();
        go(32'h2000, 32'h3000, 3, sc);
        wait_done(40);
        chk("t3_re_cycles", last_run, 16);
        chk("t3_error", error, 1);
        chk("t3_done_lat", done_cyc - sc, 18);
        chk("t3_reads", rd_log.size(), 0);
        fixed_lat = 1;
        tick();
        go(32'h2000, 32'h3000, 1, sc);
        chk("t3_error_cleared", error, 0);
        wait_done(20);
        chk("t3_error_after", error, 0);
        // source address wrap
        go(32'hFFFF_FFFC, 32'h400, 2, sc);
        wait_done(30);
        chk("t4_rd0", rd_log[0], 32'hFFFF_FFFC);
        chk("t4_rd1", rd_log[1], 32'h0000_0000);
        chk("t4_wr1_data", wr_log[1], 32'h5A5A_0000);
        // abort in WR of word 2, coinciding with its ack; start while busy ignored
        go(32'h500, 32'h600, 5, sc);
        repeat (2) tick();
        src_addr = 32'h7000; word_count = 1; start = 1;
        tick();
        start = 0;
        k = 0;
        while (!(bus_we != 0 && wr_log.size() == 1) && k < 50) begin tick(); k++; end
        chk("t5_reach_wr2", k < 50, 1);
        tick();
        abort = 1; dc = done_cnt;
        tick();
        abort = 0;
        chk("t5_we_off", bus_we, 0);
        chk("t5_busy_off", busy, 0);
        repeat (5) tick();
        chk("t5_no_done", done_cnt, dc);
        chk("t5_writes", wr_log.size(), 1);
        // random latency, reset mid-copy, then a full copy
        rand_lat = 1;
        go(32'h8000, 32'h9000, 64, sc);
        repeat (100) tick();
        chk("t6_busy_before", busy, 1);
        chk("t6_partial", wr_log.size() < 64, 1);
        #2 reset_l = 0;
        #1;
        chk("t6_async_ctl", {busy, done, error, bus_re, bus_we}, 0);
        chk("t6_async_bus", {bus_addr, bus_wr_data}, 0);
        repeat (2) tick();
        reset_l = 1;
        go(32'h8000, 32'h9000, 64, sc);
        wait_done(2000);
        chk("t6_writes", wr_log.size(), 64);
        chk("t6_last_data", wr_log[63], 32'h5A5A_80FC);
        chk("t6_error", error, 0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
